// File: rtl/carrier_pkg.sv
// Shared types and saturating arithmetic helpers for the carrier-recovery loop.
package carrier_pkg;

  // Widest data width supported by the helpers; sums are formed one bit wider.
  localparam int MAXW = 64;

  typedef enum logic {ACQ, TRACK} state_t;

  typedef logic signed [MAXW:0] wide_t;

  function automatic wide_t lim_max(input int unsigned w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t lim_min(input int unsigned w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // Add two sign-extended w-bit operands and clip to the w-bit range.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
    s = a + b;
    if (s > lim_max(w))      return lim_max(w);
    else if (s < lim_min(w)) return lim_min(w);
    else                     return s;
  endfunction

  // True when the same add would have clipped.
  function automatic logic sat_clip(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
    s = a + b;
    return (s > lim_max(w)) || (s < lim_min(w));
  endfunction

  // Magnitude of a w-bit value; the most-negative code maps to max positive.
  function automatic wide_t abs_sat(input wide_t a, input int unsigned w);
    if (a == lim_min(w)) return lim_max(w);
    else if (a < 0)      return -a;
    else                 return a;
  endfunction

endpackage

// File: rtl/pi_loop_filter_gs_lock_detector.sv
// Lock detector: counts consecutive in-lock / out-of-lock phase-error samples
// and decides which gain set the loop filter uses.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACQ   | acquisition gains; counting samples with |pd| < LOCK_TH
// TRACK | tracking gains; counting samples with |pd| >= UNLOCK_TH
module lock_detector
  import carrier_pkg::*;
#(
  parameter int LOCK_TH    = 4096,
  parameter int UNLOCK_TH  = 16384,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  pd_valid,
  input  wide_t pd_abs,
  input  logic  gear_en,
  output logic  locked
);

  localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CW   = $clog2(CMAX) + 1;

  state_t        state;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] unl_cnt;

  // Lock state machine; counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACQ;
      lock_cnt <= '0;
      unl_cnt  <= '0;
      locked   <= 1'b0;
    end else if (!gear_en) begin
      state    <= ACQ;
      lock_cnt <= '0;
      unl_cnt  <= '0;
      locked   <= 1'b0;
    end else if (pd_valid) begin
      case (state)
        ACQ: begin
          if (pd_abs < wide_t'(LOCK_TH)) begin
            if (lock_cnt == CW'(LOCK_CNT - 1)) begin
              state    <= TRACK;
              lock_cnt <= '0;
              unl_cnt  <= '0;
              locked   <= 1'b1;
            end else if (lock_cnt != '1) begin
              lock_cnt <= lock_cnt + CW'(1);
            end
          end else begin
            lock_cnt <= '0;
          end
        end
        TRACK: begin
          if (pd_abs >= wide_t'(UNLOCK_TH)) begin
            if (unl_cnt == CW'(UNLOCK_CNT - 1)) begin
              state    <= ACQ;
              unl_cnt  <= '0;
              lock_cnt <= '0;
              locked   <= 1'b0;
            end else if (unl_cnt != '1) begin
              unl_cnt <= unl_cnt + CW'(1);
            end
          end else begin
            // hysteresis band and in-lock samples both restart the count
            unl_cnt <= '0;
          end
        end
        default: begin
          state  <= ACQ;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pi_loop_filter_gs.sv
// Gear-shifting PI loop filter: phase error in, registered frequency
// correction out, with lock-driven selection between acquisition and
// tracking gains.
module pi_loop_filter_gs
  import carrier_pkg::*;
#(
  parameter int W          = 32,
  parameter int ACQ_KP_SH  = 2,
  parameter int ACQ_KI_SH  = 10,
  parameter int TRK_KP_SH  = 4,
  parameter int TRK_KI_SH  = 14,
  parameter int LOCK_TH    = 4096,
  parameter int UNLOCK_TH  = 16384,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pd_valid,
  input  logic signed [W-1:0] pd,
  input  logic                freeze,
  input  logic                gear_en,
  output logic signed [W-1:0] frequency_df,
  output logic                df_valid,
  output logic                locked,
  output logic                int_sat
);

  logic signed [W-1:0] integ;
  wide_t               pd_x, int_x, p_x, i_x, pd_abs;
  int unsigned         kp_sh, ki_sh;
  logic signed [W-1:0] df_next, int_next;
  logic                int_clip;

  // Gains follow the current lock state; the sum uses the old integrator.
  always_comb begin
    kp_sh    = locked ? TRK_KP_SH : ACQ_KP_SH;
    ki_sh    = locked ? TRK_KI_SH : ACQ_KI_SH;
    pd_x     = {{(MAXW + 1 - W){pd[W-1]}}, pd};
    int_x    = {{(MAXW + 1 - W){integ[W-1]}}, integ};
    p_x      = pd_x >>> kp_sh;
    i_x      = pd_x >>> ki_sh;
    pd_abs   = abs_sat(pd_x, W);
    df_next  = W'(sat_add(int_x, p_x, W));
    int_next = W'(sat_add(int_x, i_x, W));
    int_clip = sat_clip(int_x, i_x, W);
  end

  // Output, integrator and sticky saturation flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frequency_df <= '0;
      df_valid     <= 1'b0;
      integ        <= '0;
      int_sat      <= 1'b0;
    end else begin
      df_valid <= pd_valid;
      if (pd_valid) begin
        frequency_df <= df_next;
        if (!freeze) begin
          integ <= int_next;
          if (int_clip) int_sat <= 1'b1;
        end
      end
    end
  end

  lock_detector #(
    .LOCK_TH    (LOCK_TH),
    .UNLOCK_TH  (UNLOCK_TH),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_lock (
    .clk      (clk),
    .rst      (rst),
    .pd_valid (pd_valid),
    .pd_abs   (pd_abs),
    .gear_en  (gear_en),
    .locked   (locked)
  );

endmodule

// File: tb/tb_pi_loop_filter_gs.sv
// Directed bench for pi_loop_filter_gs with hand-computed expected values.
module tb_pi_loop_filter_gs;

  logic               clk = 1'b0;
  logic               rst;
  logic               pd_valid;
  logic signed [31:0] pd;
  logic               freeze;
  logic               gear_en;
  logic signed [31:0] frequency_df;
  logic               df_valid;
  logic               locked;
  logic               int_sat;

  int checks = 0;
  int errors = 0;

  pi_loop_filter_gs dut (
    .clk          (clk),
    .rst          (rst),
    .pd_valid     (pd_valid),
    .pd           (pd),
    .freeze       (freeze),
    .gear_en      (gear_en),
    .frequency_df (frequency_df),
    .df_valid     (df_valid),
    .locked       (locked),
    .int_sat      (int_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One valid sample; returns on the falling edge after it was registered.
  task automatic send(input logic [31:0] v);
    @(negedge clk);
    pd       = v;
    pd_valid = 1'b1;
    @(negedge clk);
    pd_valid = 1'b0;
  endtask

  task automatic send_n(input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) send(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    pd_valid = 1'b0;
    pd       = '0;
    freeze   = 1'b0;
    gear_en  = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_df", frequency_df, 32'd0);
    chk("reset_valid", {31'd0, df_valid}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_int_sat", {31'd0, int_sat}, 32'd0);
    rst = 1'b0;

    // mid-stream reset discards the in-flight sample
    send(32'd5000);
    chk("pre_rst_df", frequency_df, 32'd1250);
    @(negedge clk);
    pd       = 32'd1024;
    pd_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_df", frequency_df, 32'd0);
    @(negedge clk);
    chk("rst_no_valid", {31'd0, df_valid}, 32'd0);
    rst      = 1'b0;
    pd_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_no_valid", {31'd0, df_valid}, 32'd0);

    // basic: 1024 -> p=256, i=1
    send(32'd1024);
    chk("basic1_valid", {31'd0, df_valid}, 32'd1);
    chk("basic1_df", frequency_df, 32'd256);
    @(negedge clk);
    chk("basic_idle_valid", {31'd0, df_valid}, 32'd0);
    send(32'd1024);
    chk("basic2_df", frequency_df, 32'd257);
    chk("basic2_int", dut.integ, 32'd2);

    // negative rounding is floor
    do_reset();
    send(32'hFFFF_FFFF);
    chk("neg_df", frequency_df, 32'hFFFF_FFFF);
    chk("neg_int", dut.integ, 32'hFFFF_FFFF);

    // integrator saturation: i = 2097151 per sample, p = 536870911
    do_reset();
    send(32'h7FFF_FFFF);
    chk("sat1_df", frequency_df, 32'd536870911);
    chk("sat1_int", dut.integ, 32'd2097151);
    send_n(32'h7FFF_FFFF, 1023);
    chk("sat1024_int", dut.integ, 32'd2147482624);
    chk("sat1024_df_clip", frequency_df, 32'h7FFF_FFFF);
    chk("sat1024_no_flag", {31'd0, int_sat}, 32'd0);
    send(32'h7FFF_FFFF);
    chk("sat1025_int", dut.integ, 32'h7FFF_FFFF);
    chk("sat1025_flag", {31'd0, int_sat}, 32'd1);
    chk("sat1025_df", frequency_df, 32'h7FFF_FFFF);
    send(32'd0);
    chk("sat_sticky", {31'd0, int_sat}, 32'd1);
    chk("sat_hold_int", dut.integ, 32'h7FFF_FFFF);

    // freeze: preload int=1000 via 1024000>>>10
    do_reset();
    send(32'd1024000);
    chk("frz_pre_int", dut.integ, 32'd1000);
    freeze = 1'b1;
    send(32'd4096);
    chk("frz_df", frequency_df, 32'd2024);
    chk("frz_int", dut.integ, 32'd1000);
    freeze = 1'b0;
    send(32'd4096);
    chk("unfrz_df", frequency_df, 32'd2024);
    chk("unfrz_int", dut.integ, 32'd1004);

    // lock / gear shift
    do_reset();
    send_n(32'd100, 63);
    chk("lock63", {31'd0, locked}, 32'd0);
    send(32'd100);
    chk("lock64", {31'd0, locked}, 32'd1);
    chk("lock64_valid", {31'd0, df_valid}, 32'd1);
    chk("lock64_df_acq", frequency_df, 32'd25);
    send(32'd100);
    chk("trk_df", frequency_df, 32'd6);
    send_n(32'd20000, 15);
    chk("unl15", {31'd0, locked}, 32'd1);
    send(32'd10000);
    send_n(32'd20000, 15);
    chk("hyst_restart", {31'd0, locked}, 32'd1);
    send(32'd20000);
    chk("unl16", {31'd0, locked}, 32'd0);
    chk("unl16_df_trk", frequency_df, 32'd1280);
    chk("unl16_int", dut.integ, 32'd31);
    send(32'd4096);
    chk("acq_again_df", frequency_df, 32'd1055);

    // gear_en=0 drops lock without a sample
    do_reset();
    send_n(32'd100, 64);
    chk("gear_locked", {31'd0, locked}, 32'd1);
    @(negedge clk);
    gear_en = 1'b0;
    @(negedge clk);
    chk("gear_off_unlock", {31'd0, locked}, 32'd0);
    send(32'd100);
    chk("gear_off_acq_df", frequency_df, 32'd25);
    gear_en = 1'b1;
    send_n(32'd100, 63);
    chk("relock63", {31'd0, locked}, 32'd0);
    send(32'd100);
    chk("relock64", {31'd0, locked}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
